// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and data load/store (D),
// one transaction in flight, variable-latency ack, timeout abort. Optional macro ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic       TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_cnt;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_i_gnt;
    logic                  r_i_done;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic                  r_i_err;
    logic                  r_d_gnt;
    logic                  r_d_done;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_d_err;

    logic                  w_take_d;
    logic                  w_take_i;
    logic                  w_tie_d;
    logic                  w_ack;
    logic                  w_abort;
    logic                  w_end;
    logic                  w_i_end;
    logic                  w_d_end;
    logic [DATA_WIDTH-1:0] w_rdata_ret;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which side won the last grant; a tie goes to the other side.
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_take_d) begin
            r_last_d <= 1'b1;
        end else if (w_take_i) begin
            r_last_d <= 1'b0;
        end
    end

    assign w_tie_d = ~r_last_d;
`else
    assign w_tie_d = 1'b1;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_state_nxt = r_state;
        w_take_d    = 1'b0;
        w_take_i    = 1'b0;
        w_ack       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req && (!i_req || w_tie_d)) begin
                    w_take_d    = 1'b1;
                    w_state_nxt = ST_BUSY_D;
                end else if (i_req) begin
                    w_take_i    = 1'b1;
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // An ack on the timeout boundary cycle completes normally.
                w_ack   = mem_ack;
                w_abort = TO_EN && !mem_ack && (r_cnt == TO_LAST);
                if (w_ack || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_end       = w_ack | w_abort;
    assign w_i_end     = w_end && (r_state == ST_BUSY_I);
    assign w_d_end     = w_end && (r_state == ST_BUSY_D);
    assign w_rdata_ret = (w_ack && !r_mem_we) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
        end else if (w_take_d) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_we    <= d_we;
            r_mem_wdata <= d_wdata;
            r_cnt       <= '0;
        end else if (w_take_i) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= i_addr;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
        end else if (w_end) begin
            r_mem_req   <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            r_cnt       <= r_cnt + 8'd1;
        end
    end

    // Grant and done are single-cycle pulses; rdata/err hold until the next done on that side.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_gnt   <= 1'b0;
            r_i_done  <= 1'b0;
            r_i_rdata <= '0;
            r_i_err   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_d_done  <= 1'b0;
            r_d_rdata <= '0;
            r_d_err   <= 1'b0;
        end else begin
            r_i_gnt  <= w_take_i;
            r_d_gnt  <= w_take_d;
            r_i_done <= w_i_end;
            r_d_done <= w_d_end;
            if (w_i_end) begin
                r_i_rdata <= w_rdata_ret;
                r_i_err   <= w_abort;
            end
            if (w_d_end) begin
                r_d_rdata <= w_rdata_ret;
                r_d_err   <= w_abort;
            end
        end
    end

    a_one_gnt: assert property (@(posedge clk) disable iff (reset) !(r_i_gnt && r_d_gnt));
    a_one_done: assert property (@(posedge clk) disable iff (reset) !(r_i_done && r_d_done));

    assign i_gnt     = r_i_gnt;
    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_gnt     = r_d_gnt;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
